// File: rtl/contra_input_pkg.sv
// Shared definitions for the keyboard front end: PS/2 set-2 scan codes,
// prefix-tracking states, direction keycodes and the held-key decode helper.
package contra_input_pkg;

  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_S       = 8'h1B;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_UP_X    = 8'h75;
  localparam logic [7:0] SC_LEFT_X  = 8'h6B;
  localparam logic [7:0] SC_DOWN_X  = 8'h72;
  localparam logic [7:0] SC_RIGHT_X = 8'h74;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_J       = 8'h3B;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;

  localparam logic [1:0] GS_PLAY = 2'b01;

  // Bit positions in the held-key flag vector.
  localparam int KEY_UP    = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_JUMP  = 4;
  localparam int KEY_FIRE  = 5;
  localparam int NUM_KEYS  = 6;

  typedef logic [NUM_KEYS-1:0] key_flags_t;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXT_BRK
  } prefix_state_e;

  typedef enum logic [3:0] {
    KC_NONE      = 4'd0,
    KC_UP        = 4'd1,
    KC_LEFT      = 4'd2,
    KC_DOWN      = 4'd3,
    KC_RIGHT     = 4'd4,
    KC_UPLEFT    = 4'd5,
    KC_UPRIGHT   = 4'd6,
    KC_DOWNLEFT  = 4'd7,
    KC_DOWNRIGHT = 4'd8
  } keycode_e;

  // One-hot flag for a code byte; all-zero for codes the game ignores.
  function automatic key_flags_t key_mask(input logic [7:0] code, input logic ext);
    key_flags_t m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP_X:    m[KEY_UP]    = 1'b1;
        SC_LEFT_X:  m[KEY_LEFT]  = 1'b1;
        SC_DOWN_X:  m[KEY_DOWN]  = 1'b1;
        SC_RIGHT_X: m[KEY_RIGHT] = 1'b1;
        default:    m = '0;
      endcase
    end else begin
      case (code)
        SC_W:     m[KEY_UP]    = 1'b1;
        SC_A:     m[KEY_LEFT]  = 1'b1;
        SC_S:     m[KEY_DOWN]  = 1'b1;
        SC_D:     m[KEY_RIGHT] = 1'b1;
        SC_SPACE: m[KEY_JUMP]  = 1'b1;
        SC_J:     m[KEY_FIRE]  = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/direction_encoder.sv
// Maps four direction-held flags to the 0..8 movement keycode. Opposite
// directions held together cancel on that axis.
module direction_encoder
  import contra_input_pkg::*;
(
  input  logic       up_i,
  input  logic       left_i,
  input  logic       down_i,
  input  logic       right_i,
  output logic [3:0] keycode_o
);

  logic v_up, v_dn, h_l, h_r;
  keycode_e kc;

  assign v_up = up_i & ~down_i;
  assign v_dn = down_i & ~up_i;
  assign h_l  = left_i & ~right_i;
  assign h_r  = right_i & ~left_i;

  always_comb begin
    kc = KC_NONE;
    case ({v_up, v_dn, h_l, h_r})
      4'b1000: kc = KC_UP;
      4'b0100: kc = KC_DOWN;
      4'b0010: kc = KC_LEFT;
      4'b0001: kc = KC_RIGHT;
      4'b1010: kc = KC_UPLEFT;
      4'b1001: kc = KC_UPRIGHT;
      4'b0110: kc = KC_DOWNLEFT;
      4'b0101: kc = KC_DOWNRIGHT;
      default: kc = KC_NONE;
    endcase
  end

  assign keycode_o = kc;

endmodule

// File: rtl/key_input_decoder.sv
// PS/2 scan-code stream to held game keys, movement keycode and start pulse.
// Outputs are registered one cycle after the held-flag update.
module key_input_decoder
  import contra_input_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       scan_valid,
  input  logic [7:0] scan_data,
  input  logic [1:0] gameState,
  output logic [3:0] keycode,
  output logic       keyPress,
  output logic       Jumping,
  output logic       Shooting,
  output logic       startPulse
);

  prefix_state_e state_q, state_d;
  key_flags_t    flags_q, flags_d;
  logic          start_evt_q, start_evt_d;
  logic [3:0]    keycode_q;
  logic          keypress_q, jump_q, shoot_q, start_pulse_q;
  logic [3:0]    kc_raw;
  logic          play;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= PS_IDLE;
      flags_q     <= '0;
      start_evt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      start_evt_q <= start_evt_d;
    end
  end

  // Prefix tracker: E0 marks extended, F0 marks break; the final byte acts.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    start_evt_d = 1'b0;
    if (scan_valid) begin
      case (state_q)
        PS_IDLE: begin
          if (scan_data == SC_EXT)      state_d = PS_EXT;
          else if (scan_data == SC_BRK) state_d = PS_BRK;
          else begin
            flags_d     = flags_q | key_mask(scan_data, 1'b0);
            start_evt_d = (scan_data == SC_ENTER);
          end
        end
        PS_EXT: begin
          if (scan_data == SC_BRK)      state_d = PS_EXT_BRK;
          else if (scan_data != SC_EXT) begin
            flags_d = flags_q | key_mask(scan_data, 1'b1);
            state_d = PS_IDLE;
          end
        end
        PS_BRK: begin
          if (scan_data != SC_BRK) begin
            flags_d = flags_q & ~key_mask(scan_data, 1'b0);
            state_d = PS_IDLE;
          end
        end
        PS_EXT_BRK: begin
          flags_d = flags_q & ~key_mask(scan_data, 1'b1);
          state_d = PS_IDLE;
        end
        default: state_d = PS_IDLE;
      endcase
    end
  end

  direction_encoder u_dir (
    .up_i      (flags_q[KEY_UP]),
    .left_i    (flags_q[KEY_LEFT]),
    .down_i    (flags_q[KEY_DOWN]),
    .right_i   (flags_q[KEY_RIGHT]),
    .keycode_o (kc_raw)
  );

  assign play = (gameState == GS_PLAY);

  // Flags keep tracking outside play; only the reported levels are masked.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode_q     <= '0;
      keypress_q    <= 1'b0;
      jump_q        <= 1'b0;
      shoot_q       <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      keycode_q     <= play ? kc_raw : 4'd0;
      keypress_q    <= play & (flags_q[KEY_UP] | flags_q[KEY_LEFT] | flags_q[KEY_DOWN]
                              | flags_q[KEY_RIGHT] | flags_q[KEY_JUMP]);
      jump_q        <= play & flags_q[KEY_JUMP];
      shoot_q       <= play & flags_q[KEY_FIRE];
      start_pulse_q <= start_evt_q;
    end
  end

  assign keycode    = keycode_q;
  assign keyPress   = keypress_q;
  assign Jumping    = jump_q;
  assign Shooting   = shoot_q;
  assign startPulse = start_pulse_q;

endmodule
